uart_boot_loader: RTL

Serial program loader that sits directly upstream of the pipelined core. It receives a length-prefixed, checksummed program image over a UART line and writes it word by word into the instruction/data BRAM. The core is held in reset for the whole load and released only after a verified image is in memory. Port A write signals are muxed into the BRAM by the integrating top while `core_rst_n` is low.

---
 rtl/uart_boot_loader.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/uart_boot_loader.sv
// UART program loader: receives a length-prefixed, checksummed image over 8N1 serial,
// writes it word by word into BRAM port A and releases the core once the image verifies.
module uart_boot_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int MAX_WORDS    = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_rst_n,
    output logic        load_done,
    output logic        load_error
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_BIT    = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL_BIT_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {LD_LEN, LD_DATA, LD_CSUM, LD_RUN, LD_ERR} ld_state_t;

    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
        csum_add = sum + data;
    endfunction

    rx_state_t       rx_state_r, rx_next_s;
    ld_state_t       ld_state_r, ld_next_s;
    logic            rx_meta_r, rx_sync_r, rx_prev_r;
    logic [CW-1:0]   rx_cnt_r;
    logic [2:0]      bit_idx_r;
    logic [7:0]      shift_r;
    logic            byte_valid_r, frame_err_r;
    logic [1:0]      byte_cnt_r;
    logic [31:0]     word_r, len_r, idx_r;
    logic [7:0]      csum_r;
    logic            fall_s, rx_tick_s;
    logic [31:0]     word_next_s;

    assign fall_s      = rx_prev_r & ~rx_sync_r;
    assign rx_tick_s   = (rx_cnt_r == CNT_ZERO);
    assign word_next_s = {shift_r, word_r[31:8]};

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Receiver state register
    always_ff @(posedge clk) begin
        if (rst) rx_state_r <= RX_IDLE;
        else     rx_state_r <= rx_next_s;
    end

    // Receiver next-state logic
    always_comb begin
        rx_next_s = rx_state_r;
        case (rx_state_r)
            RX_IDLE:  if (fall_s) rx_next_s = RX_START; else rx_next_s = RX_IDLE;
            RX_START: begin
                if (rx_tick_s) rx_next_s = rx_sync_r ? RX_IDLE : RX_DATA;
                else           rx_next_s = RX_START;
            end
            RX_DATA:  if (rx_tick_s && bit_idx_r == 3'd7) rx_next_s = RX_STOP; else rx_next_s = RX_DATA;
            RX_STOP:  if (rx_tick_s) rx_next_s = RX_IDLE; else rx_next_s = RX_STOP;
            default:  rx_next_s = RX_IDLE;
        endcase
    end

    // Receiver bit timing, shift register and one-cycle byte/error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt_r     <= CNT_ZERO;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'h00;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    rx_cnt_r  <= HALF_BIT;
                    bit_idx_r <= 3'd0;
                end
                RX_START: rx_cnt_r <= rx_tick_s ? FULL_BIT_M1 : rx_cnt_r - CNT_ONE;
                RX_DATA: begin
                    if (rx_tick_s) begin
                        shift_r   <= {rx_sync_r, shift_r[7:1]};
                        bit_idx_r <= bit_idx_r + 3'd1;
                        rx_cnt_r  <= FULL_BIT_M1;
                    end else begin
                        rx_cnt_r <= rx_cnt_r - CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_tick_s) begin
                        byte_valid_r <= rx_sync_r;
                        frame_err_r  <= ~rx_sync_r;
                    end else begin
                        rx_cnt_r <= rx_cnt_r - CNT_ONE;
                    end
                end
                default: rx_cnt_r <= CNT_ZERO;
            endcase
        end
    end

    // Loader state register
    always_ff @(posedge clk) begin
        if (rst) ld_state_r <= LD_LEN;
        else     ld_state_r <= ld_next_s;
    end

    // Loader next-state logic; RUN and ERR are terminal until reset
    always_comb begin
        ld_next_s = ld_state_r;
        case (ld_state_r)
            LD_LEN: begin
                if (frame_err_r) ld_next_s = LD_ERR;
                else if (byte_valid_r && byte_cnt_r == 2'd3) begin
                    if (word_next_s == 32'd0 || word_next_s > 32'(MAX_WORDS)) ld_next_s = LD_ERR;
                    else ld_next_s = LD_DATA;
                end else ld_next_s = LD_LEN;
            end
            LD_DATA: begin
                if (frame_err_r) ld_next_s = LD_ERR;
                else if (byte_valid_r && byte_cnt_r == 2'd3 && idx_r == len_r - 32'd1) ld_next_s = LD_CSUM;
                else ld_next_s = LD_DATA;
            end
            LD_CSUM: begin
                if (frame_err_r) ld_next_s = LD_ERR;
                else if (byte_valid_r) ld_next_s = (shift_r == csum_r) ? LD_RUN : LD_ERR;
                else ld_next_s = LD_CSUM;
            end
            LD_RUN:  ld_next_s = LD_RUN;
            LD_ERR:  ld_next_s = LD_ERR;
            default: ld_next_s = LD_ERR;
        endcase
    end

    // Loader datapath: word assembly, checksum, BRAM write port and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_r <= 2'd0;
            word_r     <= 32'd0;
            len_r      <= 32'd0;
            idx_r      <= 32'd0;
            csum_r     <= 8'h00;
            mem_we     <= 4'h0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            core_rst_n <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            mem_we     <= 4'h0;
            core_rst_n <= (ld_next_s == LD_RUN);
            load_done  <= (ld_next_s == LD_RUN);
            load_error <= (ld_next_s == LD_ERR);
            if (byte_valid_r && (ld_state_r == LD_LEN || ld_state_r == LD_DATA)) begin
                byte_cnt_r <= byte_cnt_r + 2'd1;
                word_r     <= word_next_s;
                if (ld_state_r == LD_LEN) begin
                    if (byte_cnt_r == 2'd3) begin
                        len_r  <= word_next_s;
                        idx_r  <= 32'd0;
                        csum_r <= 8'h00;
                    end
                end else begin
                    csum_r <= csum_add(csum_r, shift_r);
                    if (byte_cnt_r == 2'd3) begin
                        mem_we    <= 4'hF;
                        mem_addr  <= {idx_r[29:0], 2'b00};
                        mem_wdata <= word_next_s;
                        idx_r     <= idx_r + 32'd1;
                    end
                end
            end
        end
    end
endmodule
